// File: rtl/nx_stream_pkg.sv
// -----------------------------------------------------------------------------
// nx_stream_pkg
//   Shared definitions for the nx_stream_mux packet multiplexer.
//   - state_e   : lock FSM state encoding (IDLE / LOCKED)
//   - idx_width : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package nx_stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Never returns 0 so an index port stays legal even for a single channel.
  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/nx_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nx_stream_rr_arbiter
//   Purely combinational round-robin picker. It starts at ptr_i and walks
//   upward, wrapping CHANNELS-1 -> 0. The first requester found wins.
//
// Ports
//   req_i    in   CHANNELS   request vector (one bit per channel)
//   ptr_i    in   ID_WIDTH   highest-priority channel for this cycle
//   grant_o  out  CHANNELS   one-hot grant, all zero when nothing requests
//   idx_o    out  ID_WIDTH   index of the granted channel
//   valid_o  out  1          a grant was issued
// -----------------------------------------------------------------------------
module nx_stream_rr_arbiter
  import nx_stream_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ID_WIDTH = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                valid_o
);

  always_comb begin
    int                cand;
    logic [ID_WIDTH-1:0] cand_idx;
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= CHANNELS) begin
        cand = cand - CHANNELS;
      end
      cand_idx = ID_WIDTH'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/nx_stream_mux.sv
// -----------------------------------------------------------------------------
// nx_stream_mux
//   Merges CHANNELS AXI4-Stream style inbound streams into one outbound
//   stream. Whole packets are kept together: once a multi-beat packet has
//   started, its channel owns the output until its tlast beat is accepted.
//   Arbitration between packets is round-robin. The outbound side is a
//   single register stage, so the latency is 1. It still sustains one beat
//   per cycle, because the stage can reload in the same cycle it drains.
//
// Ports
//   clk                in   1                  clock, rising edge
//   rst                in   1                  async reset, active high
//   inbound_tdata_i    in   CHANNELS*W         channel n in slice n
//   inbound_tlast_i    in   CHANNELS           per-channel end-of-packet
//   inbound_tvalid_i   in   CHANNELS           per-channel beat valid
//   inbound_tready_o   out  CHANNELS           per-channel accept (<=1 hot)
//   outbound_tdata_o   out  W                  merged beat data
//   outbound_tlast_o   out  1                  merged end-of-packet
//   outbound_tdest_o   out  ID_WIDTH           source channel of the beat
//   outbound_tvalid_o  out  1                  merged beat valid
//   outbound_tready_i  in   1                  downstream accept
//   status_active      out  1                  a packet holds the lock
//   status_idle        out  1                  idle, no requests, output empty
//   status_packets     out  32                 delivered packet count (wraps)
// -----------------------------------------------------------------------------
module nx_stream_mux
  import nx_stream_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int CHANNELS        = 2,
  parameter int ID_WIDTH        = idx_width(CHANNELS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS*AXI4_DATA_WIDTH-1:0] inbound_tdata_i,
  input  logic [CHANNELS-1:0]                 inbound_tlast_i,
  input  logic [CHANNELS-1:0]                 inbound_tvalid_i,
  output logic [CHANNELS-1:0]                 inbound_tready_o,
  output logic [AXI4_DATA_WIDTH-1:0]          outbound_tdata_o,
  output logic                                outbound_tlast_o,
  output logic [ID_WIDTH-1:0]                 outbound_tdest_o,
  output logic                                outbound_tvalid_o,
  input  logic                                outbound_tready_i,
  output logic                                status_active,
  output logic                                status_idle,
  output logic [31:0]                         status_packets
);

  localparam int W = AXI4_DATA_WIDTH;

  state_e              state_q;
  logic [ID_WIDTH-1:0] owner_q;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [W-1:0]        out_data_q;
  logic [ID_WIDTH-1:0] out_dest_q;
  logic [31:0]         pkt_cnt_q;

  logic [CHANNELS-1:0] arb_grant;
  logic [ID_WIDTH-1:0] arb_idx;
  logic                arb_valid;

  logic [ID_WIDTH-1:0] sel_idx;
  logic                sel_valid;
  logic                sel_last;
  logic [W-1:0]        sel_data;
  logic                can_load;
  logic                accept;
  logic [ID_WIDTH-1:0] rr_ptr_d;
  logic [CHANNELS-1:0] tready_d;

  nx_stream_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_i   (inbound_tvalid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    // The lock owner bypasses the arbiter. Other channels are invisible
    // until the owner's tlast is accepted.
    if (state_q == ST_LOCKED) begin
      sel_idx   = owner_q;
      sel_valid = inbound_tvalid_i[owner_q];
    end else begin
      sel_idx   = arb_idx;
      sel_valid = arb_valid;
    end
    sel_last = inbound_tlast_i[sel_idx];
    sel_data = inbound_tdata_i[sel_idx*W +: W];

    // The output stage can take a new beat if it is empty or draining this
    // cycle. Gating with rst keeps every tready low while reset is asserted.
    can_load = !out_valid_q || outbound_tready_i;
    accept   = sel_valid && can_load && !rst;

    tready_d = '0;
    if (accept) begin
      tready_d[sel_idx] = 1'b1;
    end

    if (sel_idx == ID_WIDTH'(CHANNELS - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_last_q  <= sel_last;
        out_data_q  <= sel_data;
        out_dest_q  <= sel_idx;
        if (sel_last) begin
          // Single-beat packets pass straight through IDLE. They never
          // take the lock, but they still advance the round-robin pointer.
          state_q  <= ST_IDLE;
          rr_ptr_q <= rr_ptr_d;
        end else begin
          state_q <= ST_LOCKED;
          owner_q <= sel_idx;
        end
      end else if (outbound_tready_i) begin
        out_valid_q <= 1'b0;
      end

      if (out_valid_q && outbound_tready_i && out_last_q) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  assign inbound_tready_o  = tready_d;
  assign outbound_tdata_o  = out_data_q;
  assign outbound_tlast_o  = out_last_q;
  assign outbound_tdest_o  = out_dest_q;
  assign outbound_tvalid_o = out_valid_q;
  assign status_active     = (state_q == ST_LOCKED);
  assign status_idle       = rst ||
                             ((state_q == ST_IDLE) && !(|inbound_tvalid_i) && !out_valid_q);
  assign status_packets    = pkt_cnt_q;

endmodule

// File: tb/tb_nx_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_nx_stream_mux
//   Directed bench for nx_stream_mux. It uses three instances:
//     u_a : default parameters (128-bit, 2 channels)
//     u_b : 4 channels, 32-bit, single-beat round-robin traffic
//     u_c : 3 channels, 64-bit, data-width pass-through
//   Each source channel is a packet generator. Beat data encodes
//   (channel << 8) | sequence number, so every expected beat can be
//   written down by hand.
// -----------------------------------------------------------------------------
module tb_nx_stream_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: defaults
  logic [255:0] a_tdata;
  logic [1:0]   a_tlast, a_tvalid, a_tready;
  logic [127:0] a_odata;
  logic         a_olast, a_ovalid, a_ordy, a_active, a_idle;
  logic [0:0]   a_odest;
  logic [31:0]  a_pkts;

  // instance B: 4 channels x 32 bits
  logic [127:0] b_tdata;
  logic [3:0]   b_tlast, b_tvalid, b_tready;
  logic [31:0]  b_odata;
  logic         b_olast, b_ovalid, b_active, b_idle;
  logic         b_ordy = 1'b1;
  logic [1:0]   b_odest;
  logic [31:0]  b_pkts;

  // instance C: 3 channels x 64 bits
  logic [191:0] c_tdata;
  logic [2:0]   c_tlast, c_tvalid, c_tready;
  logic [63:0]  c_odata;
  logic         c_olast, c_ovalid, c_active, c_idle;
  logic         c_ordy = 1'b1;
  logic [1:0]   c_odest;
  logic [31:0]  c_pkts;

  nx_stream_mux u_a (
    .clk(clk), .rst(rst),
    .inbound_tdata_i(a_tdata), .inbound_tlast_i(a_tlast),
    .inbound_tvalid_i(a_tvalid), .inbound_tready_o(a_tready),
    .outbound_tdata_o(a_odata), .outbound_tlast_o(a_olast),
    .outbound_tdest_o(a_odest), .outbound_tvalid_o(a_ovalid),
    .outbound_tready_i(a_ordy),
    .status_active(a_active), .status_idle(a_idle), .status_packets(a_pkts)
  );

  nx_stream_mux #(.AXI4_DATA_WIDTH(32), .CHANNELS(4)) u_b (
    .clk(clk), .rst(rst),
    .inbound_tdata_i(b_tdata), .inbound_tlast_i(b_tlast),
    .inbound_tvalid_i(b_tvalid), .inbound_tready_o(b_tready),
    .outbound_tdata_o(b_odata), .outbound_tlast_o(b_olast),
    .outbound_tdest_o(b_odest), .outbound_tvalid_o(b_ovalid),
    .outbound_tready_i(b_ordy),
    .status_active(b_active), .status_idle(b_idle), .status_packets(b_pkts)
  );

  nx_stream_mux #(.AXI4_DATA_WIDTH(64), .CHANNELS(3)) u_c (
    .clk(clk), .rst(rst),
    .inbound_tdata_i(c_tdata), .inbound_tlast_i(c_tlast),
    .inbound_tvalid_i(c_tvalid), .inbound_tready_o(c_tready),
    .outbound_tdata_o(c_odata), .outbound_tlast_o(c_olast),
    .outbound_tdest_o(c_odest), .outbound_tvalid_o(c_ovalid),
    .outbound_tready_i(c_ordy),
    .status_active(c_active), .status_idle(c_idle), .status_packets(c_pkts)
  );

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;   // 0: sources feed/observe u_a, 1: u_b

  logic [3:0] src_en;
  logic [3:0] src_hold;
  int         src_len[4];
  int         src_beat[4];
  int         src_seq[4];
  int         src_npk[4];   // packets left; negative = endless

  function automatic logic [31:0] data_of(input int c, input int s);
    return 32'((c << 8) | s);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 2; c++) begin
      a_tvalid[c]           = src_en[c] && !src_hold[c];
      a_tlast[c]            = (src_beat[c] == src_len[c] - 1);
      a_tdata[c*128 +: 128] = 128'(data_of(c, src_seq[c]));
    end
    for (int c = 0; c < 4; c++) begin
      b_tvalid[c]         = src_en[c] && !src_hold[c];
      b_tlast[c]          = (src_beat[c] == src_len[c] - 1);
      b_tdata[c*32 +: 32] = data_of(c, src_seq[c]);
    end
  endtask

  task automatic redrive();
    drive();
    #1;
  endtask

  // One clock: note which channels handshake, let the edge pass, and then
  // advance those sources. Returns 2 time units after the edge.
  task automatic tick();
    logic [3:0] acc;
    acc = (mode == 0) ? {2'b00, a_tready & a_tvalid} : (b_tready & b_tvalid);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (acc[c]) begin
        src_seq[c]++;
        if (src_beat[c] == src_len[c] - 1) begin
          src_beat[c] = 0;
          if (src_npk[c] > 0) begin
            src_npk[c]--;
            if (src_npk[c] == 0) src_en[c] = 1'b0;
          end
        end else begin
          src_beat[c]++;
        end
      end
    end
    redrive();
  endtask

  task automatic src_clear();
    for (int c = 0; c < 4; c++) begin
      src_en[c]   = 1'b0;
      src_hold[c] = 1'b0;
      src_len[c]  = 1;
      src_beat[c] = 0;
      src_seq[c]  = 0;
      src_npk[c]  = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_clear();
    redrive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  int ct_dest[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  int ct_seq[9]  = '{0, 1, 2, 0, 1, 2, 3, 4, 5};

  initial begin
    a_ordy   = 1'b1;
    c_tdata  = '0;
    c_tlast  = '0;
    c_tvalid = '0;
    do_reset();

    // post-reset state
    chk("rst_ovalid", 128'(a_ovalid), 128'(0));
    chk("rst_odata",  a_odata, 128'(0));
    chk("rst_pkts",   128'(a_pkts), 128'(0));
    chk("rst_idle",   128'(a_idle), 128'(1));
    chk("rst_active", 128'(a_active), 128'(0));

    // contention: 3-beat packets on ch0 (x2) and ch1 (x1), no gaps
    src_len[0] = 3; src_npk[0] = 2; src_en[0] = 1'b1;
    src_len[1] = 3; src_npk[1] = 1; src_en[1] = 1'b1;
    redrive();
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("ct_valid", 128'(a_ovalid), 128'(1));
      chk("ct_dest",  128'(a_odest), 128'(ct_dest[k]));
      chk("ct_data",  a_odata, 128'(data_of(ct_dest[k], ct_seq[k])));
      chk("ct_last",  128'(a_olast), 128'((k % 3) == 2));
    end
    tick();
    chk("ct_drain", 128'(a_ovalid), 128'(0));
    chk("ct_pkts",  128'(a_pkts), 128'(3));
    chk("ct_idle",  128'(a_idle), 128'(1));

    // reset mid-packet on ch1
    src_len[1] = 3; src_npk[1] = 1; src_en[1] = 1'b1;
    redrive();
    tick();
    tick();
    chk("mr_pre_data",   a_odata, 128'(data_of(1, 4)));
    chk("mr_pre_active", 128'(a_active), 128'(1));
    rst = 1'b1;
    #1;
    chk("mr_tready", 128'(a_tready), 128'(0));
    chk("mr_ovalid", 128'(a_ovalid), 128'(0));
    chk("mr_pkts",   128'(a_pkts), 128'(0));
    chk("mr_active", 128'(a_active), 128'(0));
    chk("mr_idle",   128'(a_idle), 128'(1));
    chk("mr_odata",  a_odata, 128'(0));
    src_beat[1] = 0;
    redrive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_first_ovalid", 128'(a_ovalid), 128'(0));
    chk("mr_first_tready", 128'(a_tready), 128'(2));
    tick();
    chk("mr_b0_valid", 128'(a_ovalid), 128'(1));
    chk("mr_b0_dest",  128'(a_odest), 128'(1));
    chk("mr_b0_data",  a_odata, 128'(data_of(1, 5)));
    chk("mr_b0_last",  128'(a_olast), 128'(0));
    tick();
    tick();
    chk("mr_b2_data", a_odata, 128'(data_of(1, 7)));
    chk("mr_b2_last", 128'(a_olast), 128'(1));
    tick();
    chk("mr_pkts_after", 128'(a_pkts), 128'(1));

    // lock: ch0 4-beat packet, pauses after beat 1 while ch1 waits
    do_reset();
    src_len[0] = 4; src_npk[0] = 1; src_en[0] = 1'b1;
    src_len[1] = 3; src_npk[1] = 1; src_en[1] = 1'b1;
    redrive();
    tick();
    chk("lk_b0_data", a_odata, 128'(data_of(0, 0)));
    tick();
    chk("lk_b1_data", a_odata, 128'(data_of(0, 1)));
    src_hold[0] = 1'b1;
    redrive();
    chk("lk_gap_tready", 128'(a_tready), 128'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lk_gap_ovalid", 128'(a_ovalid), 128'(0));
      chk("lk_gap_tready", 128'(a_tready), 128'(0));
      chk("lk_gap_active", 128'(a_active), 128'(1));
    end
    src_hold[0] = 1'b0;
    redrive();
    tick();
    chk("lk_b2_dest", 128'(a_odest), 128'(0));
    chk("lk_b2_data", a_odata, 128'(data_of(0, 2)));
    tick();
    chk("lk_b3_data", a_odata, 128'(data_of(0, 3)));
    chk("lk_b3_last", 128'(a_olast), 128'(1));
    tick();
    chk("lk_ch1_dest", 128'(a_odest), 128'(1));
    chk("lk_ch1_data", a_odata, 128'(data_of(1, 0)));

    // backpressure: downstream stalls 5 cycles with beat 0 held
    do_reset();
    src_len[0] = 4; src_npk[0] = 1; src_en[0] = 1'b1;
    redrive();
    tick();
    a_ordy = 1'b0;
    redrive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid",  128'(a_ovalid), 128'(1));
      chk("bp_hold_data",   a_odata, 128'(data_of(0, 0)));
      chk("bp_hold_tready", 128'(a_tready), 128'(0));
    end
    a_ordy = 1'b1;
    redrive();
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("bp_data", a_odata, 128'(data_of(0, k)));
      chk("bp_last", 128'(a_olast), 128'(k == 3));
    end
    tick();
    chk("bp_drain", 128'(a_ovalid), 128'(0));
    chk("bp_pkts",  128'(a_pkts), 128'(1));

    // single-beat packets on 4 channels: strict rotation, never locked
    do_reset();
    mode = 1;
    for (int c = 0; c < 4; c++) begin
      src_len[c] = 1; src_npk[c] = -1; src_en[c] = 1'b1;
    end
    redrive();
    chk("sb_tready0", 128'(b_tready), 128'(1));
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("sb_valid",  128'(b_ovalid), 128'(1));
      chk("sb_dest",   128'(b_odest), 128'((k - 1) % 4));
      chk("sb_data",   128'(b_odata), 128'(data_of((k - 1) % 4, (k - 1) / 4)));
      chk("sb_active", 128'(b_active), 128'(0));
      chk("sb_pkts",   128'(b_pkts), 128'(k - 1));
      chk("sb_tready", 128'(b_tready), 128'(1 << (k % 4)));
    end

    // width: 64-bit beat from channel 2 of a 3-channel mux
    mode = 0;
    do_reset();
    c_tdata[63:0]    = 64'h1111_2222_3333_4444;
    c_tdata[128 +: 64] = 64'hDEADBEEF_CAFEF00D;
    c_tvalid         = 3'b100;
    c_tlast          = 3'b100;
    #1;
    chk("wd_tready", 128'(c_tready), 128'(4));
    @(posedge clk);
    #1;
    c_tvalid = 3'b000;
    chk("wd_data",  128'(c_odata), 128'(64'hDEADBEEF_CAFEF00D));
    chk("wd_dest",  128'(c_odest), 128'(2));
    chk("wd_valid", 128'(c_ovalid), 128'(1));
    chk("wd_last",  128'(c_olast), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nx_stream_mux.md
NX_STREAM_MUX -- requirements
Module: nx_stream_mux

Interface
REQ-001 Parameter AXI4_DATA_WIDTH, default 128, sets the beat width of every stream.
REQ-002 Parameter CHANNELS, default 2, sets the number of inbound streams; legal range 2..16.
REQ-003 Parameter ID_WIDTH, default $clog2(CHANNELS), sets the width of the channel tag.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, exposed as the ports below.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 inbound_tdata_i  input  CHANNELS*AXI4_DATA_WIDTH  packed per-channel beat data; channel n occupies slice n.
REQ-008 inbound_tlast_i  input  CHANNELS  per-channel end-of-packet.
REQ-009 inbound_tvalid_i  input  CHANNELS  per-channel beat valid.
REQ-010 inbound_tready_o  output  CHANNELS  per-channel beat accept.
REQ-011 outbound_tdata_o  output  AXI4_DATA_WIDTH  merged beat data.
REQ-012 outbound_tlast_o  output  1  merged end-of-packet.
REQ-013 outbound_tdest_o  output  ID_WIDTH  source channel index of the current beat.
REQ-014 outbound_tvalid_o  output  1  merged beat valid.
REQ-015 outbound_tready_i  input  1  downstream accept.
REQ-016 status_active  output  1  high while a packet is locked (LOCKED state).
REQ-017 status_idle  output  1  high when state is IDLE, no inbound tvalid and output register empty.
REQ-018 status_packets  output  32  count of packets (tlast beats) delivered downstream, wraps at 2^32.

Function
REQ-019 States: IDLE (no lock) and LOCKED (lock held by channel owner); no other states.
REQ-020 In IDLE with any inbound tvalid, the block SHALL select the requesting channel first at or after rr_ptr (round-robin, wrapping CHANNELS-1 -> 0) combinationally in the same cycle.
REQ-021 A beat SHALL be accepted from a channel only when that channel is granted/owner, its tvalid is high and the output register can load (empty or outbound_tready_i high).
REQ-022 At most one bit of inbound_tready_o SHALL be high in any cycle; a non-granted channel's tready SHALL be 0.
REQ-023 Accepted non-tlast beat in IDLE -> LOCKED with owner = granted channel.
REQ-024 In LOCKED only the owner is served; other channels' tvalid are ignored regardless of duration.
REQ-025 Accepted tlast beat (either state) -> IDLE; rr_ptr = source channel + 1 modulo CHANNELS.
REQ-026 Single-beat packets SHALL not enter LOCKED.
REQ-027 Back-to-back packets from different channels SHALL incur zero bubble cycles on the outbound stream.
REQ-028 Output register: accepted beat appears on outbound_* the following cycle (latency 1); data, tlast, tdest held stable while tvalid high and tready low.
REQ-029 Sustained throughput SHALL be one beat per cycle when outbound_tready_i is held high.
REQ-030 status_packets SHALL increment by one on each outbound cycle with tvalid, tready and tlast all high.
REQ-031 Owner tvalid dropping mid-packet SHALL keep LOCKED with no beats emitted; no timeout.

Reset
REQ-032 On rst assertion, immediately: state IDLE, rr_ptr 0, outbound_tvalid_o 0, inbound_tready_o all 0, status_packets 0, status_active 0.
REQ-033 outbound_tdata_o, tlast, tdest SHALL reset to 0.
REQ-034 Reset mid-packet SHALL discard the partial packet and the output register contents; no beat issued in the first cycle after deassertion.
REQ-035 status_idle SHALL read 1 during reset.

Structure
REQ-036 Shared package nx_stream_pkg SHALL hold the state enum (IDLE, LOCKED) and the channel-index width helper.
REQ-037 Round-robin selection SHALL live in sub-module nx_stream_rr_arbiter (request vector and pointer in, one-hot grant and index out, purely combinational).

Verification
REQ-038 Reset: assert rst mid-packet on channel 1 -> all tready 0, outbound_tvalid 0, status_packets 0, next packet starts cleanly.
REQ-039 Contention: channels 0 and 1 each send continuous 3-beat packets, tready high -> outbound tdest pattern 0,0,0,1,1,1,0,0,0, no gaps.
REQ-040 Lock: channel 0 sends 4-beat packet with tvalid gap after beat 2 while channel 1 valid -> no channel-1 beat until channel 0 tlast.
REQ-041 Backpressure: outbound_tready low 5 cycles mid-packet -> output held stable, no beat lost or duplicated, order preserved.
REQ-042 Single-beat: CHANNELS=4, all channels send 1-beat packets continuously -> tdest 0,1,2,3,0..., status_active never high, status_packets +1 per cycle.
REQ-043 Width: AXI4_DATA_WIDTH=64, CHANNELS=3 -> data 0xDEADBEEF_CAFEF00D from channel 2 emerges unchanged with tdest 2.
